// File: rtl/ble4_pkg.sv
// ble4_pkg: shared constants and configuration FSM states for the BLE4 LUT front end
package ble4_pkg;
  localparam int LUT_K = 4;
  localparam int CFG_BITS = 2**LUT_K + 1;
  localparam int CFG_OSEL_BIT = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, READY} cfg_state_e;
endpackage

// File: rtl/ble4_cfg_chain.sv
// ble4_cfg_chain: serial configuration shift register with saturating shift counter
module ble4_cfg_chain #(
  parameter int N = 17,
  parameter int W = $clog2(N + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift,
  input  logic         restart,
  input  logic         din,
  output logic         dout,
  output logic [N-1:0] cfg,
  output logic [W-1:0] cnt
);
  // N+1 marks an overrun and is held so an overlong load still reports an error
  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg <= '0;
      cnt <= '0;
    end else if (shift) begin
      cfg <= {din, cfg[N-1:1]};
      cnt <= restart ? W'(1) : (cnt == W'(N + 1) ? cnt : cnt + 1'b1);
    end
  end
  assign dout = cfg[0];
endmodule

// File: rtl/ble4_lut_cfg.sv
// ble4_lut_cfg: configurable LUT4 with serial config chain, load guard FSM and output select
module ble4_lut_cfg #(
  parameter int LUT_K = 4,
  parameter int CFG_BITS = 2**LUT_K + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ccff_head,
  input  logic             cfg_en,
  output logic             ccff_tail,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic [LUT_K-1:0] lut_in,
  output logic             ff_D,
  input  logic             ff_Q,
  output logic             ble_out
);
  import ble4_pkg::*;
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  cfg_state_e state, nxt;
  logic [CFG_BITS-1:0] cfg;
  logic [CNT_W-1:0] cnt;
  logic [2**LUT_K-1:0] mask;
  logic restart, set_err, full, ready, lut_o;
  ble4_cfg_chain #(.N(CFG_BITS), .W(CNT_W)) u_chain (
    .clk(clk),
    .reset(reset),
    .shift(cfg_en),
    .restart(restart),
    .din(ccff_head),
    .dout(ccff_tail),
    .cfg(cfg),
    .cnt(cnt)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cfg_err <= 1'b0;
    end else begin
      state <= nxt;
      if (set_err) cfg_err <= 1'b1;
    end
  end
  always_comb begin
    full = cnt == CNT_W'(CFG_BITS);
    restart = cfg_en && state != SHIFT;
    set_err = state == SHIFT && !cfg_en && !full;
    nxt = cfg_en ? SHIFT : (state == SHIFT ? (full ? READY : IDLE) : state);
  end
  // a partial chain never reaches the fabric: outputs are forced low outside READY
  assign ready = state == READY;
  assign mask = cfg[2**LUT_K-1:0];
  assign lut_o = mask[lut_in];
  assign cfg_done = ready;
  assign ff_D = ready & lut_o;
  assign ble_out = ready & (cfg[CFG_OSEL_BIT] ? lut_o : ff_Q);
endmodule
